// File: rtl/turn_controller_pkg.sv
// Shared types for the naval-battle turn controller: FSM state codes,
// board geometry and the row/column to cell-bit mapping.
package turn_pkg;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int CELLS = 35;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AIM    = 3'd1,
        CHECK  = 3'd2,
        RESULT = 3'd3,
        WON    = 3'd4,
        LOST   = 3'd5
    } state_t;

    function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(row * COLS + col);
    endfunction

endpackage

// File: rtl/turn_controller_btn_debounce.sv
// Fire button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on the debounced press (high-to-low) edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The button is active-low, so "released" is the all-ones reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// One game turn of the 7x5 naval-battle board: fire debounce, shot FSM,
// score state and multiplexed LED matrix scan. Optional macro: CURSOR_BLINK_EN.
module turn_controller
    import turn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_SHOTS       = 20,
    parameter int RESULT_CYCLES   = 25000000,
    parameter int SCAN_DIV        = 50000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic [2:0]                     row_sel,
    input  logic [2:0]                     col_sel,
    input  logic                           fire_btn,
    input  logic [34:0]                    ship_map,
    output logic [34:0]                    shot_map,
    output logic [34:0]                    hit_map,
    output logic                           led_hit,
    output logic                           led_miss,
    output logic [$clog2(MAX_SHOTS+1)-1:0] shots_left,
    output logic [5:0]                     hits,
    output logic [2:0]                     state,
    output logic                           game_over,
    output logic [6:0]                     mat_rows,
    output logic [4:0]                     mat_cols
);

    localparam int SHOT_W = $clog2(MAX_SHOTS + 1);
    localparam int RES_W  = $clog2(RESULT_CYCLES + 1);
    localparam int DIV_W  = $clog2(SCAN_DIV + 1);

    state_t           state_q, state_d;
    logic [34:0]      ship_q;
    logic [5:0]       sel_idx, aim_idx, slice_base;
    logic             in_range, fire_pulse, fire_ok, res_done, won;
    logic [RES_W-1:0] res_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       row_q;
    logic [4:0]       cols_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (fire_btn),
        .press (fire_pulse)
    );

    assign sel_idx   = cell_index(row_sel, col_sel);
    assign in_range  = (row_sel < 3'(ROWS)) && (col_sel < 3'(COLS));
    assign fire_ok   = fire_pulse && in_range && !shot_map[sel_idx];
    assign res_done  = (res_cnt == RES_W'(RESULT_CYCLES - 1));
    assign won       = (ship_q != '0) && ((ship_q & ~hit_map) == '0);
    assign state     = state_q;
    assign game_over = (state_q == WON) || (state_q == LOST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mode) state_d = AIM;
            AIM:     if (fire_ok) state_d = CHECK;
            CHECK:   state_d = RESULT;
            RESULT: begin
                if (res_done) begin
                    if (won)                   state_d = WON;
                    else if (shots_left == '0) state_d = LOST;
                    else                       state_d = AIM;
                end
            end
            default: state_d = state_q;
        endcase
        // Leaving play mode aborts whatever turn is in flight.
        if (!mode) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shot_map   <= '0;
            hit_map    <= '0;
            ship_q     <= '0;
            led_hit    <= 1'b0;
            led_miss   <= 1'b0;
            shots_left <= SHOT_W'(MAX_SHOTS);
            hits       <= '0;
            res_cnt    <= '0;
            aim_idx    <= '0;
        end else if (!mode) begin
            shot_map   <= '0;
            hit_map    <= '0;
            led_hit    <= 1'b0;
            led_miss   <= 1'b0;
            shots_left <= SHOT_W'(MAX_SHOTS);
            hits       <= '0;
            res_cnt    <= '0;
        end else begin
            case (state_q)
                IDLE: ship_q <= ship_map;
                // Cell is captured on the accepting edge so later aim moves cannot retarget it.
                AIM:  aim_idx <= sel_idx;
                CHECK: begin
                    shot_map[aim_idx] <= 1'b1;
                    shots_left        <= shots_left - 1'b1;
                    if (ship_q[aim_idx]) begin
                        hit_map[aim_idx] <= 1'b1;
                        hits             <= hits + 1'b1;
                        led_hit          <= 1'b1;
                    end else begin
                        led_miss <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_done) begin
                        res_cnt  <= '0;
                        led_hit  <= 1'b0;
                        led_miss <= 1'b0;
                    end else begin
                        res_cnt <= res_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [21:0] blink_cnt;
    logic        blink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) blink <= ~blink;
        end
    end
`endif

    always_comb begin
        slice_base = cell_index(row_q, 3'd0);
        cols_d     = '0;
        case (state_q)
            AIM, CHECK, RESULT: cols_d = shot_map[slice_base +: 5];
            WON:                cols_d = 5'b11111;
            LOST:               cols_d = ship_q[slice_base +: 5];
            default:            cols_d = '0;
        endcase
`ifdef CURSOR_BLINK_EN
        if (state_q == AIM && in_range && row_sel == row_q)
            cols_d = cols_d ^ (5'(blink) << col_sel);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            row_q    <= '0;
            mat_rows <= 7'b0000001;
            mat_cols <= '0;
        end else begin
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                row_q   <= (row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            mat_rows <= 7'b0000001 << row_q;
            mat_cols <= cols_d;
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller (default build, CURSOR_BLINK_EN undefined) with
// short debounce/result/scan timings; a game-level model predicts every shot.
module tb_turn_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode, fire_btn;
    logic [2:0]  row_sel, col_sel;
    logic [34:0] ship_map;
    logic [34:0] shot_map, hit_map;
    logic        led_hit, led_miss, game_over;
    logic [4:0]  shots_left;
    logic [5:0]  hits;
    logic [2:0]  state;
    logic [6:0]  mat_rows;
    logic [4:0]  mat_cols;

    int checks   = 0;
    int failures = 0;

    // Game-level model
    logic [34:0] m_ship, m_shot, m_hit;
    int          m_left, m_hits, m_state;

    always #5 clk = ~clk;

    turn_controller #(
        .DEBOUNCE_CYCLES(4),
        .MAX_SHOTS      (20),
        .RESULT_CYCLES  (8),
        .SCAN_DIV       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .row_sel    (row_sel),
        .col_sel    (col_sel),
        .fire_btn   (fire_btn),
        .ship_map   (ship_map),
        .shot_map   (shot_map),
        .hit_map    (hit_map),
        .led_hit    (led_hit),
        .led_miss   (led_miss),
        .shots_left (shots_left),
        .hits       (hits),
        .state      (state),
        .game_over  (game_over),
        .mat_rows   (mat_rows),
        .mat_cols   (mat_cols)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_shot(input int r, input int c, output bit acc, output bit hit);
        int idx;
        acc = 0;
        hit = 0;
        if (m_state != 1) return;
        if (r > 6 || c > 4) return;
        idx = r * 5 + c;
        if (m_shot[idx]) return;
        acc = 1;
        m_shot[idx] = 1'b1;
        m_left--;
        if (m_ship[idx]) begin
            hit = 1;
            m_hit[idx] = 1'b1;
            m_hits++;
        end
        if (m_ship != 0 && m_hit == m_ship) m_state = 4;
        else if (m_left == 0)               m_state = 5;
    endtask

    // One full press/release of the fire button while watching the turn unfold.
    task automatic shot(input int r, input int c, output bit acc, output int hc, output int mc);
        row_sel = 3'(r);
        col_sel = 3'(c);
        acc = 0;
        hc  = 0;
        mc  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state == 3'd2) acc = 1;
            if (led_hit)  hc++;
            if (led_miss) mc++;
            fire_btn = (i < 10) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic fire_chk(input int r, input int c);
        bit acc, hit, dacc;
        int hc, mc;
        model_shot(r, c, acc, hit);
        shot(r, c, dacc, hc, mc);
        chk("accept", 64'(dacc), 64'(acc));
        chk("led_hit_cycles", 64'(hc), hit ? 64'd8 : 64'd0);
        chk("led_miss_cycles", 64'(mc), (acc && !hit) ? 64'd8 : 64'd0);
        chk("state", 64'(state), 64'(m_state));
        chk("shots_left", 64'(shots_left), 64'(m_left));
        chk("hits", 64'(hits), 64'(m_hits));
        chk("shot_map", 64'(shot_map), 64'(m_shot));
        chk("hit_map", 64'(hit_map), 64'(m_hit));
        chk("game_over", 64'(game_over), 64'(m_state >= 4));
    endtask

    task automatic new_game(input logic [34:0] ship);
        mode     = 1'b0;
        fire_btn = 1'b1;
        ship_map = ship;
        repeat (3) @(negedge clk);
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_shot_map", 64'(shot_map), 64'd0);
        chk("idle_shots_left", 64'(shots_left), 64'd20);
        chk("idle_mat_cols", 64'(mat_cols), 64'd0);
        mode = 1'b1;
        repeat (2) @(negedge clk);
        chk("aim_entry", 64'(state), 64'd1);
        ship_map = ~ship;  // must not affect the latched map
        m_ship  = ship;
        m_shot  = '0;
        m_hit   = '0;
        m_left  = 20;
        m_hits  = 0;
        m_state = 1;
    endtask

    task automatic check_scan(input logic [34:0] map, input string name);
        int errs = 0;
        int r;
        bit wrap = 0;
        logic [6:0] prev;
        logic [4:0] exp5;
        prev = mat_rows;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ($countones(mat_rows) != 1) begin
                errs++;
            end else begin
                r = 0;
                for (int k = 0; k < 7; k++) if (mat_rows[k]) r = k;
                exp5 = 5'(map >> (r * 5));
                if (mat_cols !== exp5) errs++;
            end
            if (prev == 7'h40 && mat_rows == 7'h01) wrap = 1;
            prev = mat_rows;
        end
        chk({name, "_scan_cols"}, 64'(errs), 64'd0);
        chk({name, "_scan_wrap"}, 64'(wrap), 64'd1);
    endtask

    typedef struct {
        int r;
        int c;
        bit acc;
        bit hit;
        int st;
        int left;
        int nhits;
    } vec_t;

    initial begin
        vec_t tbl[7];
        bit   acc, found;
        int   hc, mc, bad;
        logic [34:0] ship;

        mode = 1'b0; fire_btn = 1'b1; row_sel = '0; col_sel = '0; ship_map = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_mat_rows", 64'(mat_rows), 64'h01);
        chk("rst_mat_cols", 64'(mat_cols), 64'd0);
        chk("rst_shots_left", 64'(shots_left), 64'd20);
        chk("rst_leds", 64'({led_hit, led_miss}), 64'd0);
        chk("rst_hits", 64'(hits), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Scripted game from a table
        tbl[0] = '{7, 0, 0, 0, 1, 20, 0};
        tbl[1] = '{1, 2, 1, 1, 1, 19, 1};
        tbl[2] = '{1, 2, 0, 0, 1, 19, 1};
        tbl[3] = '{0, 0, 1, 0, 1, 18, 1};
        tbl[4] = '{0, 5, 0, 0, 1, 18, 1};
        tbl[5] = '{6, 3, 1, 1, 4, 17, 2};
        tbl[6] = '{2, 2, 0, 0, 4, 17, 2};
        ship = (35'(1) << 7) | (35'(1) << 33);
        new_game(ship);
        for (int i = 0; i < 7; i++) begin
            shot(tbl[i].r, tbl[i].c, acc, hc, mc);
            chk("tbl_accept", 64'(acc), 64'(tbl[i].acc));
            chk("tbl_led_hit", 64'(hc), tbl[i].hit ? 64'd8 : 64'd0);
            chk("tbl_led_miss", 64'(mc), (tbl[i].acc && !tbl[i].hit) ? 64'd8 : 64'd0);
            chk("tbl_state", 64'(state), 64'(tbl[i].st));
            chk("tbl_shots_left", 64'(shots_left), 64'(tbl[i].left));
            chk("tbl_hits", 64'(hits), 64'(tbl[i].nhits));
        end
        chk("tbl_hit_map", 64'(hit_map), 64'(ship));
        check_scan(35'h7_FFFF_FFFF, "won");

        // Single-ship game won on first shot
        new_game(35'(1) << 7);
        fire_chk(1, 2);
        chk("s2_won", 64'(state), 64'd4);
        chk("s2_game_over", 64'(game_over), 64'd1);

        // Glitch rejection and out-of-range aim
        new_game(35'h1);
        row_sel = 3'd0; col_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fire_btn = 1'b0;
        end
        @(negedge clk);
        fire_btn = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (state != 3'd1) bad++;
        end
        chk("glitch_state", 64'(bad), 64'd0);
        chk("glitch_shots_left", 64'(shots_left), 64'd20);
        fire_chk(7, 0);

        // Repeat shot, then exhaust all shots on misses
        new_game(35'(1) << 34);
        fire_chk(0, 0);
        fire_chk(0, 0);
        chk("repeat_left", 64'(shots_left), 64'd19);
        check_scan(m_shot, "aim");
        for (int k = 1; k < 20; k++) fire_chk(k / 5, k % 5);
        chk("s4_lost", 64'(state), 64'd5);
        check_scan(m_ship, "lost");

        // Last shot sinks the final ship cell
        new_game((35'(1) << 34) | 35'h1);
        for (int k = 1; k < 19; k++) fire_chk(k / 5, k % 5);
        fire_chk(0, 0);
        chk("s5_left_one", 64'(shots_left), 64'd1);
        fire_chk(6, 4);
        chk("s5_won", 64'(state), 64'd4);

        // Empty fleet can only lose
        new_game('0);
        for (int k = 0; k < 20; k++) fire_chk(k / 5, k % 5);
        chk("empty_lost", 64'(state), 64'd5);

        // mode=0 during CHECK
        new_game(35'h1);
        row_sel = 3'd0; col_sel = 3'd0;
        fire_btn = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd2) found = 1;
        end
        chk("reach_check", 64'(found), 64'd1);
        mode = 1'b0;
        @(negedge clk);
        chk("abort_check_state", 64'(state), 64'd0);
        chk("abort_check_shot_map", 64'(shot_map), 64'd0);
        chk("abort_check_left", 64'(shots_left), 64'd20);
        chk("abort_check_leds", 64'({led_hit, led_miss}), 64'd0);

        // mode=0 during RESULT
        new_game(35'h1);
        fire_btn = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd3) found = 1;
        end
        chk("reach_result", 64'(found), 64'd1);
        mode = 1'b0;
        @(negedge clk);
        chk("abort_result_state", 64'(state), 64'd0);
        chk("abort_result_shot_map", 64'(shot_map), 64'd0);
        chk("abort_result_hit_map", 64'(hit_map), 64'd0);
        chk("abort_result_left", 64'(shots_left), 64'd20);
        chk("abort_result_hits", 64'(hits), 64'd0);
        chk("abort_result_led", 64'(led_hit), 64'd0);
        fire_btn = 1'b1;
        repeat (20) @(negedge clk);
        check_scan('0, "idle");

        // Press while idle is dropped, not queued
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            fire_btn = (i < 10) ? 1'b0 : 1'b1;
        end
        mode = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_press_dropped_state", 64'(state), 64'd1);
        chk("idle_press_dropped_left", 64'(shots_left), 64'd20);

        // Asynchronous reset mid-RESULT
        new_game(35'h1);
        row_sel = 3'd0; col_sel = 3'd0;
        fire_btn = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd3) found = 1;
        end
        chk("reach_result_rst", 64'(found), 64'd1);
        #2;
        rst = 1'b0; fire_btn = 1'b1; mode = 1'b0;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_shot_map", 64'(shot_map), 64'd0);
        chk("arst_hit_map", 64'(hit_map), 64'd0);
        chk("arst_left", 64'(shots_left), 64'd20);
        chk("arst_leds", 64'({led_hit, led_miss}), 64'd0);
        chk("arst_mat_rows", 64'(mat_rows), 64'h01);
        chk("arst_hits", 64'(hits), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomised games against the model
        for (int g = 0; g < 2; g++) begin
            ship = '0;
            for (int k = 0; k < 3; k++) ship |= 35'(1) << $urandom_range(0, 34);
            new_game(ship);
            for (int a = 0; a < 30 && m_state == 1; a++) begin
                int idx, r, c;
                if ($urandom_range(0, 2) == 0) begin
                    idx = 0;
                    for (int k = 0; k < 35; k++) if (ship[k] && $urandom_range(0, 1) == 1) idx = k;
                    r = idx / 5;
                    c = idx % 5;
                end else begin
                    r = $urandom_range(0, 7);
                    c = $urandom_range(0, 5);
                end
                fire_chk(r, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
